// File: rtl/display_pkg.sv
`default_nettype none
// display_pkg: shared constants, state encoding and helpers for the HEX display scheduler.
package display_pkg;

  localparam int         NIBBLE_W  = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DECODE  = 2'd2
  } state_e;

  // Largest value representable in the given number of decimal digits.
  function automatic int max_value(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_7segment.sv
`default_nettype none
// decode_7segment: BCD digit to active-low seven-segment pattern, bit 0 = segment a.
module decode_7segment
  import display_pkg::*;
(
  input  logic [3:0] decimal,
  output logic [6:0] display
);

  always_comb begin
    display = SEG_BLANK;
    case (decimal)
      4'd0:    display = 7'h40;
      4'd1:    display = 7'h79;
      4'd2:    display = 7'h24;
      4'd3:    display = 7'h30;
      4'd4:    display = 7'h19;
      4'd5:    display = 7'h12;
      4'd6:    display = 7'h02;
      4'd7:    display = 7'h78;
      4'd8:    display = 7'h00;
      4'd9:    display = 7'h10;
      default: display = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/display_scheduler.sv
`default_nettype none
// display_scheduler: binary total -> BCD (serial double-dabble) -> time-shared 7-seg decode,
// committing all digits to the HEX outputs in a single cycle.
module display_scheduler
  import display_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_value,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done
);

  localparam int                BCD_W   = NIBBLE_W * DIGITS;
  localparam int                CNT_W   = $clog2(WIDTH + 1);
  localparam int                IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [31:0]       MAX_VAL = 32'(max_value(DIGITS));
  localparam logic [WIDTH-1:0]  MAX_IN  = WIDTH'(MAX_VAL);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_CONVERT = CONVERT;
  localparam logic [1:0] S_DECODE  = DECODE;

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [WIDTH-1:0]      bin;
  logic [BCD_W-1:0]      bcd;
  logic [IDX_W-1:0]      idx;
  logic                  blank_flag;
  logic                  pend_ovf;
  logic [7*DIGITS-1:0]   shadow;

  logic                  over;
  logic [BCD_W-1:0]      bcd_adj;
  logic [NIBBLE_W-1:0]   nibble;
  logic [6:0]            dec_out;
  logic [6:0]            seg_out;
  logic [7*DIGITS-1:0]   commit;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[i*NIBBLE_W +: NIBBLE_W] >= 4'd5) begin
        r[i*NIBBLE_W +: NIBBLE_W] = r[i*NIBBLE_W +: NIBBLE_W] + 4'd3;
      end
    end
    return r;
  endfunction

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign over     = (32'(in_value) > MAX_VAL);
  assign bcd_adj  = dabble_adjust(bcd);
  assign nibble   = bcd[int'(idx)*NIBBLE_W +: NIBBLE_W];

  decode_7segment u_decode (
    .decimal (nibble),
    .display (dec_out)
  );

  // Digit 0 is exempt from blanking so a zero total still reads "0".
  assign seg_out = (blank_flag && (nibble == '0) && (idx != '0)) ? SEG_BLANK : dec_out;

  always_comb begin
    commit      = shadow;
    commit[6:0] = seg_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bin        <= '0;
      bcd        <= '0;
      idx        <= '0;
      blank_flag <= 1'b1;
      pend_ovf   <= 1'b0;
      shadow     <= '0;
      hex        <= {DIGITS{SEG_BLANK}};
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            bin      <= over ? MAX_IN : in_value;
            pend_ovf <= over;
            bcd      <= '0;
            cnt      <= CNT_W'(WIDTH);
            state    <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          bcd <= {bcd_adj[BCD_W-2:0], bin[WIDTH-1]};
          bin <= bin << 1;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            idx        <= IDX_W'(DIGITS - 1);
            blank_flag <= 1'b1;
            state      <= S_DECODE;
          end
        end
        S_DECODE: begin
          shadow[int'(idx)*7 +: 7] <= seg_out;
          if (nibble != '0) begin
            blank_flag <= 1'b0;
          end
          if (idx == '0) begin
            hex      <= commit;
            overflow <= pend_ovf;
            done     <= 1'b1;
            state    <= S_IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// tb_display_scheduler: directed vectors with a queue scoreboard checked whenever done pulses.
module tb_display_scheduler;

  localparam int         WIDTH  = 14;
  localparam int         DIGITS = 4;
  localparam int         LAT    = WIDTH + DIGITS;
  localparam logic [6:0] B      = 7'h7F;
  localparam logic [27:0] ALL_BLANK = {B, B, B, B};

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [WIDTH-1:0]    in_value = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [7*DIGITS-1:0] hex;
  logic                overflow;
  logic                busy;
  logic                done;

  display_scheduler #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_value (in_value),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .hex      (hex),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        known;
    logic        ovf;
    logic [27:0] hex;
    int          t;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_t = -1;
  int          n_xfer = 0;
  bit          spacing_on = 1'b0;
  logic [27:0] cur_hex = ALL_BLANK;
  logic        cur_ovf = 1'b0;
  int          vals[6] = '{42, 0, 9999, 12000, 305, 7};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Hand-computed patterns: digit order {d3,d2,d1,d0}, active-low, a = bit 0.
  function automatic exp_t lookup(input int v);
    exp_t e;
    e.known = 1'b1;
    e.ovf   = 1'b0;
    e.t     = 0;
    case (v)
      0:       e.hex = {B, B, B, 7'h40};
      7:       e.hex = {B, B, B, 7'h78};
      42:      e.hex = {B, B, 7'h19, 7'h24};
      305:     e.hex = {B, 7'h30, 7'h40, 7'h12};
      1000:    e.hex = {7'h79, 7'h40, 7'h40, 7'h40};
      9999:    e.hex = {7'h10, 7'h10, 7'h10, 7'h10};
      12000: begin
        e.hex = {7'h10, 7'h10, 7'h10, 7'h10};
        e.ovf = 1'b1;
      end
      default: begin
        e.hex   = ALL_BLANK;
        e.known = 1'b0;
      end
    endcase
    return e;
  endfunction

  // Transfer observer: records expected result at each accepted handshake.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset && in_valid && in_ready) begin
        e   = lookup(int'(in_value));
        e.t = cyc;
        check("vector_known", 32'(e.known), 32'd1);
        if (spacing_on && last_t >= 0) begin
          check("transfer_spacing", 32'(cyc - last_t), 32'(LAT + 1));
        end
        last_t = cyc;
        n_xfer++;
        q.push_back(e);
      end
    end
  end

  // Monitor: compares on done and verifies hex/overflow only change at commits.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        cur_hex = ALL_BLANK;
        cur_ovf = 1'b0;
      end else begin
        if (done) begin
          if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            m = q.pop_front();
            check("done_latency", 32'(cyc - m.t), 32'(LAT));
            check("commit_hex", 32'(hex), 32'(m.hex));
            check("commit_overflow", 32'(overflow), 32'(m.ovf));
            check("ready_with_done", 32'(in_ready), 32'd1);
            cur_hex = m.hex;
            cur_ovf = m.ovf;
          end
        end
        check("hex_hold", 32'(hex), 32'(cur_hex));
        check("overflow_hold", 32'(overflow), 32'(cur_ovf));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int v);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_value = WIDTH'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((q.size() != 0 || !in_ready) && n < 100);
    check("drain", 32'(q.size() == 0 && in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) begin
      tick();
      check("idle_ready", 32'(in_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_overflow", 32'(overflow), 32'd0);
      check("idle_hex", 32'(hex), 32'(ALL_BLANK));
    end

    send(42);
    check("busy_after_xfer", 32'(busy), 32'd1);
    check("ready_after_xfer", 32'(in_ready), 32'd0);
    wait_drain();
    send(0);     wait_drain();
    send(9999);  wait_drain();
    send(12000); wait_drain();
    send(305);   wait_drain();

    // Producer holds valid with a changing value; only in_ready edges capture.
    spacing_on = 1'b1;
    last_t     = -1;
    n_xfer     = 0;
    for (int k = 0; k < 60; k++) begin
      in_valid = 1'b1;
      in_value = WIDTH'(vals[k % 6]);
      tick();
    end
    in_valid = 1'b0;
    wait_drain();
    spacing_on = 1'b0;
    check("held_valid_transfers", 32'(n_xfer), 32'd4);

    // Abort a conversion with reset sampled in CONVERT cycle 7.
    send(42);
    wait_drain();
    send(1000);
    repeat (6) tick();
    check("busy_in_convert", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("ready_after_reset", 32'(in_ready), 32'd1);
    check("busy_after_reset", 32'(busy), 32'd0);
    check("hex_after_reset", 32'(hex), 32'(ALL_BLANK));
    repeat (25) tick();
    check("no_pending_after_reset", 32'(q.size()), 32'd0);

    send(7);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Sequencer that turns a binary coin total (pence) into a multi-digit seven-segment readout.
- Accepts a value over a valid/ready handshake and converts it to BCD with an iterative double-dabble (one bit per cycle).
- Time-shares a single decode_7segment instance across all digits, one digit per cycle.
- Commits all digit patterns, with leading-zero blanking, to registered HEX outputs in one cycle. Sits between the coin-counting logic and the board HEX pins.

Parameters:
- WIDTH, 14, bit width of the binary input value.
- DIGITS, 4, number of displayed decimal digits. Max displayable value is 10^DIGITS-1.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_value  in  WIDTH  binary total to display.
- in_valid  in  1  in_value is valid.
- in_ready  out  1  block can accept a value (high only in IDLE).
- hex  out  7*DIGITS  segment patterns, active-low; digit k occupies bits [7k+6:7k], k=0 is least significant.
- overflow  out  1  last committed value exceeded 10^DIGITS-1.
- busy  out  1  conversion or decode in progress.
- done  out  1  one-cycle pulse on the cycle after hex is committed.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - State IDLE.
  - hex all 7'h7F (every digit blank).
  - overflow=0, busy=0, done=0, in_ready=1.
  - Internal shift, BCD and shadow registers cleared.
- Handshake:
  - Transfer occurs at a rising edge where in_valid & in_ready.
  - in_value is captured at that edge; later changes are ignored.
  - in_valid while busy is ignored, not queued; the producer holds it.
- Saturation: if the captured value > 10^DIGITS-1, the block substitutes 10^DIGITS-1 and sets a pending overflow flag. Otherwise the pending flag is 0.
- FSM states: IDLE -> CONVERT -> DECODE -> IDLE.
  - IDLE: in_ready=1, busy=0. On transfer, go to CONVERT and load a bit counter with WIDTH.
  - CONVERT: runs exactly WIDTH cycles. Each cycle:
    - add 3 to every BCD nibble >= 5;
    - then shift {bcd, bin} left by one.
    - BCD register is 4*DIGITS bits.
    - When the counter reaches 0, go to DECODE with digit index = DIGITS-1.
  - DECODE: runs exactly DIGITS cycles, most significant digit first.
    - The current nibble drives the shared decoder; its output is written to shadow slot [index].
    - Leading-zero blanking: a blank flag starts at 1. While the flag is set and the nibble is 0, write 7'h7F instead.
    - Clear the flag on the first nonzero nibble.
    - Digit 0 is never blanked, so value 0 shows "0".
    - After index 0, go to IDLE.
  - Commit: on the DECODE->IDLE edge, hex <= shadow (with slot 0's fresh result) and overflow <= pending flag, all simultaneously. No partial updates are ever visible on hex. done=1 for the following cycle.
- Latency: for a transfer at edge T, hex and overflow update at edge T+WIDTH+DIGITS. done is high during cycle T+WIDTH+DIGITS. in_ready returns high in that same cycle, so back-to-back values are accepted every WIDTH+DIGITS+1 cycles.
- Decoder input: only nibbles 0-9 are ever presented to the decoder. Codes 10-15 never occur.
- hex holds its last committed value indefinitely between conversions.
- Reset mid-CONVERT or mid-DECODE: the operation aborts, hex is blanked, no done pulse is emitted, and the block returns to IDLE next cycle.

Decomposition:
- Shared package (display_pkg):
  - SEG_BLANK = 7'h7F;
  - state enum {IDLE, CONVERT, DECODE};
  - function computing max value 10^DIGITS-1;
  - BCD nibble width constant 4.
- One sub-module: the existing decode_7segment, instantiated once (decimal <- selected nibble, display -> shadow write data).
- The double-dabble step is an internal function, not a separate module.

Test Plan:
- Reset, then idle 5 cycles -> hex=all 7'h7F, in_ready=1, busy=0, overflow=0, done never asserted.
- in_value=42 at edge T -> at edge T+18: digit0=decoder(2), digit1=decoder(4), digits2-3=7'h7F, overflow=0; done high for exactly one cycle after that edge.
- in_value=0 -> digit0=decoder(0), digits1-3=7'h7F; in_value=9999 -> all four digits=decoder(9).
- in_value=12000 -> all four digits=decoder(9), overflow=1. Follow with in_value=305 -> digit2=decoder(3), digit1=decoder(0) (interior zero not blanked), digit0=decoder(5), digit3 blank, overflow=0.
- Hold in_valid high with changing in_value during busy -> only values present at in_ready edges are captured; transfers spaced exactly 19 cycles apart; hex never shows mixed digits from two values.
- Assert reset in CONVERT cycle 7 after displaying 42 -> hex=all 7'h7F, no done pulse, in_ready=1 the cycle after reset deasserts.
